upsample_display: RTL
=====================

Name: upsample_display

Overview:
- Reverse path of the capture chain. Stores the 28x28 8-bit image produced by the downsampler in an on-chip frame buffer.
- Replays the image to the VGA side as 10-bit RGB.
- Each stored pixel is replicated into a 16x16 block. The resulting 448x448 window is centred in a 640x480 raster, and the border is black.
- Sits between the downsample/classifier input path and the VGA controller. Used as a preview of what the network sees.

Parameters:
H_TOTAL, 640, active raster width in pixels (1-based count)
V_TOTAL, 480, active raster height in lines (1-based count)
IMG_DIM, 28, stored image side length
BLK, 16, replication factor per stored pixel (power of two)
H_START, 97, first in-window H count
V_START, 17, first in-window V count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe for one downsampled pixel
wr_pixel  in  8  downsampled grey/BW pixel
wr_restart  in  1  rewind write pointer, clear image_ready
image_ready  out  1  all 784 pixels written since last restart/reset
pix_en  in  1  VGA pixel-advance enable (one per displayed pixel)
frame_start  out  1  1-cycle pulse registered with the H=1,V=1 output pixel
o_valid  out  1  oRed/oGreen/oBlue valid this cycle
oRed  out  10  display red
oGreen  out  10  display green
oBlue  out  10  display blue

Behaviour:
- Reset (reset=0, async): H_cont=1, V_cont=1, wr_ptr=0, image_ready=0, o_valid=0, frame_start=0, oRed/oGreen/oBlue=0. Buffer contents are not cleared and are undefined until written.
- Write side:
  - When wr_en=1 and image_ready=0, write wr_pixel to buffer[wr_ptr], then wr_ptr++.
  - On the write with wr_ptr=783, set image_ready=1 and return wr_ptr to 0.
  - While image_ready=1, wr_en is ignored: no write, and the pointer holds.
  - wr_restart=1: wr_ptr<=0, image_ready<=0. It has priority over a simultaneous wr_en, and that pixel is dropped.
- Raster counters:
  - Advance only on cycles with pix_en=1.
  - H_cont runs 1..H_TOTAL, then wraps to 1. V_cont increments when H_cont==H_TOTAL, and wraps from V_TOTAL to 1 at the same point.
  - pix_en=0 freezes all counters.
- Window test: in_win = H_START <= H_cont <= H_START+IMG_DIM*BLK-1 (97..544) and V_START <= V_cont <= V_START+IMG_DIM*BLK-1 (17..464).
- Address: col=(H_cont-H_START)>>log2(BLK), row=(V_cont-V_START)>>log2(BLK), rd_addr=row*IMG_DIM+col (0..783). rd_addr is only meaningful when in_win=1.
- Read timing:
  - The buffer read is synchronous. Sample rd_addr and in_win on the pix_en cycle.
  - Outputs are registered with exactly 1-cycle latency: o_valid = pix_en delayed by 1 cycle.
  - frame_start = (pix_en and H_cont==1 and V_cont==1), delayed by 1 cycle.
  - Outputs hold their value while o_valid=0.
- Read/write collision on the same address in the same cycle: the read returns the old data (read-before-write). There is no tearing protection beyond this.
- Colour expansion, in window: oRed=oGreen=oBlue={p[7:0], p[7:6]}. Examples: 255->1023, 100->401, 0->0.
- Outside the window: all channels 0.
- image_ready does not gate the display; the window always shows the buffer contents.
- Reset mid-frame: raster restarts at H=1,V=1 on the first pix_en after release. A partial write restarts at address 0.

Test Plan:
- Reset, then 784 writes of wr_pixel=addr[7:0] with gaps in wr_en -> image_ready rises on the cycle after the 784th write. A 785th write is ignored and buffer[0] still holds 0.
- Full image of 255, then one frame with pix_en every cycle -> o_valid count 307200. Output 1023 exactly for H 97..544, V 17..464. All other pixels 0. Exactly one frame_start, on the first o_valid.
- Buffer[1]=8'd100, all others 0 -> output 401 exactly at H 113..128, V 17..32, and 0 elsewhere. Checks block replication and the col boundary at H=112/113.
- Buffer[783]=8'hC3 -> output {C3,2'b11}=783 at H 529..544, V 449..464. Pixel H=545 reads 0. Checks the last-address and window-edge case.
- pix_en toggled 1/0 randomly -> outputs only update one cycle after pix_en, and the image is identical to the continuous run. wr_restart together with wr_en at wr_ptr=5 -> wr_ptr=0, image_ready=0, pixel not written.
- Assert reset at H=300,V=200 mid-frame, release -> all outputs 0 during reset. The first o_valid after release carries frame_start=1. wr_ptr=0.

Source files
------------

// File: rtl/upsample_display.sv
// Frame-buffer preview: stores a downsampled IMG_DIM x IMG_DIM image and replays it, each pixel
// blown up to a BLK x BLK block, centred in the VGA raster with a black border.
module upsample_display #(
    parameter int unsigned H_TOTAL = 640,
    parameter int unsigned V_TOTAL = 480,
    parameter int unsigned IMG_DIM = 28,
    parameter int unsigned BLK     = 16,
    parameter int unsigned H_START = 97,
    parameter int unsigned V_START = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_pixel,
    input  logic       wr_restart,
    output logic       image_ready,
    input  logic       pix_en,
    output logic       frame_start,
    output logic       o_valid,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue
);

    localparam int unsigned NPIX  = IMG_DIM * IMG_DIM;
    localparam int unsigned AW    = $clog2(NPIX);
    localparam int unsigned HW    = $clog2(H_TOTAL + 1);
    localparam int unsigned VW    = $clog2(V_TOTAL + 1);
    localparam int unsigned SHIFT = $clog2(BLK);
    localparam int unsigned H_END = H_START + IMG_DIM * BLK - 1;
    localparam int unsigned V_END = V_START + IMG_DIM * BLK - 1;

    logic [7:0]    buffer [NPIX];
    logic [AW-1:0] wr_ptr;
    logic          wr_do;
    logic [HW-1:0] h_cont;
    logic [HW-1:0] h_off;
    logic [VW-1:0] v_cont;
    logic [VW-1:0] v_off;
    logic          in_win;
    logic          win_q;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    // A restart in the same cycle as a write drops that pixel.
    assign wr_do = wr_en & ~image_ready & ~wr_restart;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            image_ready <= 1'b0;
        end else if (wr_restart) begin
            wr_ptr      <= '0;
            image_ready <= 1'b0;
        end else if (wr_do) begin
            if (wr_ptr == AW'(NPIX - 1)) begin
                wr_ptr      <= '0;
                image_ready <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // No reset so the array maps onto block RAM; NBA ordering gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_do) begin
            buffer[wr_ptr] <= wr_pixel;
        end
        if (pix_en) begin
            rd_data <= buffer[rd_addr];
        end
    end

    always_comb begin
        h_off   = h_cont - HW'(H_START);
        v_off   = v_cont - VW'(V_START);
        in_win  = (h_cont >= HW'(H_START)) && (h_cont <= HW'(H_END)) &&
                  (v_cont >= VW'(V_START)) && (v_cont <= VW'(V_END));
        rd_addr = '0;
        if (in_win) begin
            rd_addr = AW'(32'(v_off >> SHIFT) * IMG_DIM + 32'(h_off >> SHIFT));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cont      <= HW'(1);
            v_cont      <= VW'(1);
            o_valid     <= 1'b0;
            frame_start <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            o_valid     <= pix_en;
            frame_start <= pix_en && (h_cont == HW'(1)) && (v_cont == VW'(1));
            if (pix_en) begin
                win_q <= in_win;
                if (h_cont == HW'(H_TOTAL)) begin
                    h_cont <= HW'(1);
                    if (v_cont == VW'(V_TOTAL)) begin
                        v_cont <= VW'(1);
                    end else begin
                        v_cont <= v_cont + 1'b1;
                    end
                end else begin
                    h_cont <= h_cont + 1'b1;
                end
            end
        end
    end

    // win_q and rd_data only change on pix_en cycles, so the outputs hold in between.
    assign oRed   = win_q ? {rd_data, rd_data[7:6]} : 10'd0;
    assign oGreen = oRed;
    assign oBlue  = oRed;

endmodule
